// File: rtl/cell_grid_pkg.sv
// Shared constants, FSM state type and index helpers for the 10x10 cell grid.
// Optional mark counter is enabled by defining CELL_GRID_COUNT_EN.
package cell_grid_pkg;
  localparam int ROWS  = 10;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = 4;
  localparam int BIT_W = 7;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, TOGGLE, CLEAR} state_e;

  function automatic logic [BIT_W-1:0] cell_idx(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
    return BIT_W'(row) * BIT_W'(COLS) + BIT_W'(col);
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] row,
                                    input logic [IDX_W-1:0] col);
    return (row < IDX_W'(ROWS)) && (col < IDX_W'(COLS));
  endfunction
endpackage

// File: rtl/cell_grid_mem.sv
// 100-bit cell bitmap: one toggle/zero write port and a registered, range-checked read port.
// With CELL_GRID_COUNT_EN the pre-write value of the addressed bit is exported.
module cell_grid_mem
  import cell_grid_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [BIT_W-1:0] wr_idx_i,
  input  logic             wr_toggle_i,
  input  logic [IDX_W-1:0] rd_row_i,
  input  logic [IDX_W-1:0] rd_col_i,
  output logic             rd_data_o
`ifdef CELL_GRID_COUNT_EN
  ,
  output logic             wr_old_o
`endif
);

  logic [CELLS-1:0] bits_q, bits_d;
  logic             rd_data_q, rd_data_d;

  always_comb begin
    bits_d = bits_q;
    if (wr_en_i) begin
      bits_d[wr_idx_i] = wr_toggle_i ? ~bits_q[wr_idx_i] : 1'b0;
    end
  end

  // Read samples the pre-write bitmap, so a same-edge write returns the old bit.
  always_comb begin
    rd_data_d = 1'b0;
    if (in_range(rd_row_i, rd_col_i)) begin
      rd_data_d = bits_q[cell_idx(rd_row_i, rd_col_i)];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bits_q    <= '0;
      rd_data_q <= 1'b0;
    end else begin
      bits_q    <= bits_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
`ifdef CELL_GRID_COUNT_EN
  assign wr_old_o = bits_q[wr_idx_i];
`endif

endmodule

// File: rtl/cell_grid_store.sv
// Cell grid controller: toggle/clear FSM in front of the bitmap, plus renderer read port.
// Define CELL_GRID_COUNT_EN to add mark_count_out (population of the bitmap).
module cell_grid_store
  import cell_grid_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [IDX_W-1:0] sel_row_in,
  input  logic [IDX_W-1:0] sel_col_in,
  input  logic             sel_valid_in,
  input  logic             clear_in,
  output logic             busy_out,
  output logic             ack_out,
  output logic             reject_out,
  input  logic [IDX_W-1:0] rd_row_in,
  input  logic [IDX_W-1:0] rd_col_in,
  output logic             rd_data_out
`ifdef CELL_GRID_COUNT_EN
  ,
  output logic [BIT_W-1:0] mark_count_out
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [BIT_W-1:0] clr_idx_q, clr_idx_d;
  logic             ack_q, ack_d, reject_q, reject_d;
  logic             wr_en, wr_toggle;
  logic [BIT_W-1:0] wr_idx;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    clr_idx_d = clr_idx_q;
    ack_d     = 1'b0;
    reject_d  = 1'b0;
    wr_en     = 1'b0;
    wr_toggle = 1'b1;
    wr_idx    = cell_idx(row_q, col_q);
    case (state_q)
      IDLE: begin
        // Clear has priority; a simultaneous select is dropped.
        if (clear_in) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          reject_d  = sel_valid_in;
        end else if (sel_valid_in) begin
          if (in_range(sel_row_in, sel_col_in)) begin
            row_d   = sel_row_in;
            col_d   = sel_col_in;
            state_d = TOGGLE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      TOGGLE: begin
        wr_en    = 1'b1;
        state_d  = IDLE;
        ack_d    = 1'b1;
        reject_d = sel_valid_in;
      end
      CLEAR: begin
        wr_en     = 1'b1;
        wr_toggle = 1'b0;
        wr_idx    = clr_idx_q;
        clr_idx_d = clr_idx_q + BIT_W'(1);
        reject_d  = sel_valid_in;
        if (clr_idx_q == LAST_BIT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      clr_idx_q <= '0;
      ack_q     <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      clr_idx_q <= clr_idx_d;
      ack_q     <= ack_d;
      reject_q  <= reject_d;
    end
  end

  assign busy_out   = (state_q != IDLE);
  assign ack_out    = ack_q;
  assign reject_out = reject_q;

`ifdef CELL_GRID_COUNT_EN
  logic             wr_old;
  logic [BIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_en && wr_toggle) begin
      count_d = wr_old ? count_q - BIT_W'(1) : count_q + BIT_W'(1);
    end else if (wr_en && wr_old) begin
      count_d = count_q - BIT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) count_q <= '0;
    else           count_q <= count_d;
  end

  assign mark_count_out = count_q;
`endif

  cell_grid_mem u_mem (
    .clk_i       (clk_in),
    .rst_n_i     (rst_n_in),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_toggle_i (wr_toggle),
    .rd_row_i    (rd_row_in),
    .rd_col_i    (rd_col_in),
    .rd_data_o   (rd_data_out)
`ifdef CELL_GRID_COUNT_EN
    ,
    .wr_old_o    (wr_old)
`endif
  );

endmodule
